// File: rtl/glyph_string_renderer.sv
// Glyph string renderer: turns the scan position into glyph ROM reads and aligns the returned texels.
// Optional build macro GLYPH_SCALE2X_EN draws every texel as a 2x2 block.
module glyph_string_renderer #(
    parameter int GLYPH_W    = 30,
    parameter int GLYPH_H    = 45,
    parameter int MAX_GLYPHS = 16,
    parameter int IDX_W      = 5,
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 5
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              pix_en,
    input  logic              frame_start,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        origin_x,
    input  logic [9:0]        origin_y,
    input  logic              wr_en,
    input  logic [3:0]        wr_slot,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [4:0]        wr_len,
    input  logic              commit,
    output logic              commit_pending,
    output logic [ADDR_W-1:0] rom_read_address,
    output logic [IDX_W-1:0]  rom_idx,
    input  logic [DATA_W-1:0] rom_data_in,
    output logic              pixel_hit,
    output logic [DATA_W-1:0] pixel_color
);

`ifdef GLYPH_SCALE2X_EN
    localparam int SCALE = 2;
`else
    localparam int SCALE = 1;
`endif
    localparam int COL_W  = $clog2(GLYPH_W);
    localparam int BASE_W = $clog2(GLYPH_W * GLYPH_H);
    localparam int SLOT_W = $clog2(MAX_GLYPHS + 1);
    localparam int IDXS_W = $clog2(MAX_GLYPHS);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(GLYPH_W - 1);
    localparam logic [BASE_W-1:0] ROW_STEP = BASE_W'(GLYPH_W);
    localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(MAX_GLYPHS);
    localparam logic [10:0]       EXT_H    = 11'(GLYPH_H * SCALE);

    logic [IDX_W-1:0]  shadow_q [MAX_GLYPHS];
    logic [IDX_W-1:0]  active_q [MAX_GLYPHS];
    logic [SLOT_W-1:0] activeLen_q, pendLen_q, lenSat;
    logic              pending_q;

    logic [9:0]        originX_q, originY_q;
    logic [COL_W-1:0]  col_q, colCur, col_d;
    logic [SLOT_W-1:0] slot_q, slotCur, slot_d;
    logic [BASE_W-1:0] rowBase_q, rowBaseCur;
    logic              rowStarted_q, rowStartedCur;
    logic              inRow_q, inRowCur;
    logic              lineStart, yInRange, inSpan, colAdvance;
`ifdef GLYPH_SCALE2X_EN
    logic              colHalf_q, colHalfCur, rowHalf_q, rowHalfCur;
`endif

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              valid1_q, valid2_q, span1_q, span2_q;
    logic              hit_q;
    logic [DATA_W-1:0] color_q;

    assign lenSat = (wr_len > 5'(MAX_GLYPHS)) ? SLOT_MAX : SLOT_W'(wr_len);

    // Shadow buffer takes writes freely; the active copy only changes at frame start so text never tears.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < MAX_GLYPHS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            activeLen_q <= '0;
            pendLen_q   <= '0;
            pending_q   <= 1'b0;
        end else begin
            if (wr_en && ({1'b0, wr_slot} < 5'(MAX_GLYPHS)))
                shadow_q[wr_slot[IDXS_W-1:0]] <= wr_idx;
            if (frame_start && (pending_q || commit)) begin
                active_q    <= shadow_q;
                activeLen_q <= commit ? lenSat : pendLen_q;
                pending_q   <= 1'b0;
            end else if (commit) begin
                pending_q <= 1'b1;
            end
            if (commit)
                pendLen_q <= lenSat;
        end
    end

    assign lineStart = (DrawX == originX_q);
    assign yInRange  = ({1'b0, DrawY} >= {1'b0, originY_q}) &&
                       ({1'b0, DrawY} < ({1'b0, originY_q} + EXT_H));

    // Resolve the counters as seen by the pixel being presented now, then derive what follows it.
    always_comb begin
        colCur        = col_q;
        slotCur       = slot_q;
        rowBaseCur    = rowBase_q;
        rowStartedCur = rowStarted_q;
        inRowCur      = inRow_q;
`ifdef GLYPH_SCALE2X_EN
        colHalfCur    = colHalf_q;
        rowHalfCur    = rowHalf_q;
`endif
        if (lineStart) begin
            colCur   = '0;
            slotCur  = '0;
            inRowCur = yInRange;
`ifdef GLYPH_SCALE2X_EN
            colHalfCur = 1'b0;
`endif
            if (yInRange) begin
                rowStartedCur = 1'b1;
                if (rowStarted_q) begin
`ifdef GLYPH_SCALE2X_EN
                    rowHalfCur = ~rowHalf_q;
                    if (rowHalf_q)
                        rowBaseCur = rowBase_q + ROW_STEP;
`else
                    rowBaseCur = rowBase_q + ROW_STEP;
`endif
                end
            end
        end

`ifdef GLYPH_SCALE2X_EN
        colAdvance = colHalfCur;
`else
        colAdvance = 1'b1;
`endif
        col_d  = colCur;
        slot_d = slotCur;
        if (colAdvance) begin
            if (colCur == COL_LAST) begin
                col_d = '0;
                if (slotCur != SLOT_MAX)
                    slot_d = slotCur + 1'b1;
            end else begin
                col_d = colCur + 1'b1;
            end
        end

        inSpan = inRowCur && (DrawX >= originX_q) && (slotCur < activeLen_q);
        addr_d = ADDR_W'(rowBaseCur + BASE_W'(colCur));
        idx_d  = inSpan ? active_q[slotCur[IDXS_W-1:0]] : '1;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            originX_q    <= '0;
            originY_q    <= '0;
            col_q        <= '0;
            slot_q       <= '0;
            rowBase_q    <= '0;
            rowStarted_q <= 1'b0;
            inRow_q      <= 1'b0;
`ifdef GLYPH_SCALE2X_EN
            colHalf_q    <= 1'b0;
            rowHalf_q    <= 1'b0;
`endif
        end else if (frame_start) begin
            originX_q    <= origin_x;
            originY_q    <= origin_y;
            col_q        <= '0;
            slot_q       <= '0;
            rowBase_q    <= '0;
            rowStarted_q <= 1'b0;
            inRow_q      <= 1'b0;
`ifdef GLYPH_SCALE2X_EN
            colHalf_q    <= 1'b0;
            rowHalf_q    <= 1'b0;
`endif
        end else if (pix_en) begin
            col_q        <= col_d;
            slot_q       <= slot_d;
            rowBase_q    <= rowBaseCur;
            rowStarted_q <= rowStartedCur;
            inRow_q      <= inRowCur;
`ifdef GLYPH_SCALE2X_EN
            colHalf_q    <= ~colHalfCur;
            rowHalf_q    <= rowHalfCur;
`endif
        end
    end

    // Address out one cycle after the pixel, ROM answers a cycle later, result lands on the third edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            addr_q   <= '0;
            idx_q    <= '0;
            valid1_q <= 1'b0;
            valid2_q <= 1'b0;
            span1_q  <= 1'b0;
            span2_q  <= 1'b0;
            hit_q    <= 1'b0;
            color_q  <= '0;
        end else begin
            valid1_q <= pix_en;
            valid2_q <= valid1_q;
            span2_q  <= span1_q;
            if (pix_en) begin
                addr_q  <= addr_d;
                idx_q   <= idx_d;
                span1_q <= inSpan;
            end
            if (valid2_q) begin
                hit_q   <= span2_q && (rom_data_in != '0);
                color_q <= (span2_q && (rom_data_in != '0)) ? rom_data_in : '0;
            end
        end
    end

    assign commit_pending   = pending_q;
    assign rom_read_address = addr_q;
    assign rom_idx          = idx_q;
    assign pixel_hit        = hit_q;
    assign pixel_color      = color_q;

endmodule

// File: tb/tb_glyph_string_renderer.sv
// Directed bench for glyph_string_renderer with a registered ROM model.
// Build with GLYPH_SCALE2X_EN defined to exercise the 2x2 texel mode instead of the 1:1 scenarios.
module tb_glyph_string_renderer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        pix_en = 1'b0, frame_start = 1'b0;
    logic [9:0]  DrawX = '0, DrawY = '0, origin_x = '0, origin_y = '0;
    logic        wr_en = 1'b0, commit = 1'b0;
    logic [3:0]  wr_slot = '0;
    logic [4:0]  wr_idx = '0, wr_len = '0;
    logic        commit_pending, pixel_hit;
    logic [18:0] rom_read_address;
    logic [4:0]  rom_idx, pixel_color;
    logic [4:0]  romData = '0;
    logic [4:0]  romZeroVal = 5'd7;
    int          total = 0;
    int          bad = 0;

    glyph_string_renderer dut (
        .Clk(Clk), .Reset(Reset), .pix_en(pix_en), .frame_start(frame_start),
        .DrawX(DrawX), .DrawY(DrawY), .origin_x(origin_x), .origin_y(origin_y),
        .wr_en(wr_en), .wr_slot(wr_slot), .wr_idx(wr_idx), .wr_len(wr_len),
        .commit(commit), .commit_pending(commit_pending),
        .rom_read_address(rom_read_address), .rom_idx(rom_idx),
        .rom_data_in(romData), .pixel_hit(pixel_hit), .pixel_color(pixel_color)
    );

    always #5 Clk = ~Clk;

    // Glyph index all-ones reads as transparent; address 0 returns a tunable value, elsewhere the glyph index.
    always @(posedge Clk) begin
        if (rom_idx == 5'h1f)
            romData <= 5'd0;
        else if (rom_read_address == 19'd0)
            romData <= romZeroVal;
        else
            romData <= rom_idx;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic writeSlot(input logic [3:0] s, input logic [4:0] v);
        wr_en = 1'b1; wr_slot = s; wr_idx = v;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic doCommit(input logic [4:0] len);
        commit = 1'b1; wr_len = len;
        tick();
        commit = 1'b0;
    endtask

    task automatic doFrameStart(input logic [9:0] ox, input logic [9:0] oy);
        origin_x = ox; origin_y = oy; frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic pixel(input logic [9:0] x, input logic [9:0] y);
        DrawX = x; DrawY = y; pix_en = 1'b1;
        tick();
        pix_en = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        idle(2);
        total++; if (pixel_hit !== 1'b0) begin bad++; $display("[TB] FAIL reset_hit: got %0d want 0", pixel_hit); end
        total++; if (pixel_color !== 5'd0) begin bad++; $display("[TB] FAIL reset_color: got %0d want 0", pixel_color); end
        total++; if (rom_idx !== 5'd0) begin bad++; $display("[TB] FAIL reset_idx: got %0d want 0", rom_idx); end
        total++; if (commit_pending !== 1'b0) begin bad++; $display("[TB] FAIL reset_pending: got %0d want 0", commit_pending); end
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_address_path();
        romZeroVal = 5'd7;
        writeSlot(4'd0, 5'd1);
        writeSlot(4'd1, 5'd2);
        writeSlot(4'd2, 5'd3);
        doCommit(5'd3);
        total++; if (commit_pending !== 1'b1) begin bad++; $display("[TB] FAIL pending_set: got %0d want 1", commit_pending); end
        doFrameStart(10'd100, 10'd50);
        total++; if (commit_pending !== 1'b0) begin bad++; $display("[TB] FAIL pending_clr: got %0d want 0", commit_pending); end
        pixel(10'd90, 10'd50);
        total++; if (rom_idx !== 5'h1f) begin bad++; $display("[TB] FAIL idx_left_of_origin: got %0d want 31", rom_idx); end
        pixel(10'd100, 10'd50);
        total++; if (rom_idx !== 5'd1) begin bad++; $display("[TB] FAIL idx_100_50: got %0d want 1", rom_idx); end
        total++; if (rom_read_address !== 19'd0) begin bad++; $display("[TB] FAIL addr_100_50: got %0d want 0", rom_read_address); end
        idle(1);
        total++; if (pixel_hit !== 1'b0) begin bad++; $display("[TB] FAIL hit_early: got %0d want 0", pixel_hit); end
        idle(1);
        total++; if (pixel_hit !== 1'b1) begin bad++; $display("[TB] FAIL hit_t3: got %0d want 1", pixel_hit); end
        total++; if (pixel_color !== 5'd7) begin bad++; $display("[TB] FAIL color_t3: got %0d want 7", pixel_color); end
        for (int x = 101; x < 130; x++) pixel(10'(x), 10'd50);
        pixel(10'd130, 10'd50);
        total++; if (rom_idx !== 5'd2) begin bad++; $display("[TB] FAIL idx_130_50: got %0d want 2", rom_idx); end
        total++; if (rom_read_address !== 19'd0) begin bad++; $display("[TB] FAIL addr_130_50: got %0d want 0", rom_read_address); end
        pixel(10'd100, 10'd51);
        pixel(10'd101, 10'd51);
        total++; if (rom_read_address !== 19'd31) begin bad++; $display("[TB] FAIL addr_101_51: got %0d want 31", rom_read_address); end
        total++; if (rom_idx !== 5'd1) begin bad++; $display("[TB] FAIL idx_101_51: got %0d want 1", rom_idx); end
        romZeroVal = 5'd0;
        doFrameStart(10'd100, 10'd50);
        pixel(10'd100, 10'd50);
        idle(2);
        total++; if (pixel_hit !== 1'b0) begin bad++; $display("[TB] FAIL hit_transparent: got %0d want 0", pixel_hit); end
        total++; if (pixel_color !== 5'd0) begin bad++; $display("[TB] FAIL color_transparent: got %0d want 0", pixel_color); end
        romZeroVal = 5'd7;
    endtask

    task automatic test_commit_midframe();
        writeSlot(4'd0, 5'd9);
        doCommit(5'd1);
        total++; if (commit_pending !== 1'b1) begin bad++; $display("[TB] FAIL mid_pending: got %0d want 1", commit_pending); end
        pixel(10'd100, 10'd52);
        total++; if (rom_idx !== 5'd1) begin bad++; $display("[TB] FAIL mid_old_text: got %0d want 1", rom_idx); end
        doFrameStart(10'd100, 10'd50);
        total++; if (commit_pending !== 1'b0) begin bad++; $display("[TB] FAIL mid_pending_clr: got %0d want 0", commit_pending); end
        pixel(10'd100, 10'd50);
        total++; if (rom_idx !== 5'd9) begin bad++; $display("[TB] FAIL mid_new_text: got %0d want 9", rom_idx); end
        for (int x = 101; x < 130; x++) pixel(10'(x), 10'd50);
        pixel(10'd130, 10'd50);
        total++; if (rom_idx !== 5'h1f) begin bad++; $display("[TB] FAIL mid_past_len: got %0d want 31", rom_idx); end
    endtask

    task automatic test_back_to_back();
        writeSlot(4'd0, 5'd4);
        origin_x = 10'd100; origin_y = 10'd50;
        frame_start = 1'b1; commit = 1'b1; wr_len = 5'd1;
        wr_en = 1'b1; wr_slot = 4'd0; wr_idx = 5'd5;
        tick();
        frame_start = 1'b0; commit = 1'b0; wr_en = 1'b0;
        total++; if (commit_pending !== 1'b0) begin bad++; $display("[TB] FAIL same_cycle_pending: got %0d want 0", commit_pending); end
        pixel(10'd100, 10'd50);
        total++; if (rom_idx !== 5'd4) begin bad++; $display("[TB] FAIL same_cycle_prewrite: got %0d want 4", rom_idx); end
        origin_x = 10'd100; origin_y = 10'd50;
        frame_start = 1'b1; commit = 1'b1; wr_len = 5'd1;
        tick();
        frame_start = 1'b0; commit = 1'b0;
        pixel(10'd100, 10'd50);
        total++; if (rom_idx !== 5'd5) begin bad++; $display("[TB] FAIL same_cycle_postwrite: got %0d want 5", rom_idx); end
    endtask

    task automatic test_saturation();
        for (int s = 0; s < 16; s++) writeSlot(4'(s), 5'(s + 1));
        doCommit(5'd20);
        doFrameStart(10'd100, 10'd50);
        for (int x = 100; x <= 580; x++) begin
            pixel(10'(x), 10'd50);
            if (x == 550) begin
                total++; if (rom_idx !== 5'd16) begin bad++; $display("[TB] FAIL sat_last_glyph: got %0d want 16", rom_idx); end
            end
        end
        total++; if (rom_idx !== 5'h1f) begin bad++; $display("[TB] FAIL sat_past_end_idx: got %0d want 31", rom_idx); end
        idle(1);
        total++; if (pixel_color !== 5'd16) begin bad++; $display("[TB] FAIL sat_last_texel: got %0d want 16", pixel_color); end
        idle(1);
        total++; if (pixel_hit !== 1'b0) begin bad++; $display("[TB] FAIL sat_past_end_hit: got %0d want 0", pixel_hit); end
    endtask

    task automatic test_len_zero();
        doCommit(5'd0);
        doFrameStart(10'd100, 10'd50);
        pixel(10'd100, 10'd50);
        total++; if (rom_idx !== 5'h1f) begin bad++; $display("[TB] FAIL len0_idx: got %0d want 31", rom_idx); end
        idle(2);
        total++; if (pixel_hit !== 1'b0) begin bad++; $display("[TB] FAIL len0_hit: got %0d want 0", pixel_hit); end
    endtask

    task automatic test_reset_midscan();
        writeSlot(4'd0, 5'd1);
        doCommit(5'd1);
        doFrameStart(10'd100, 10'd50);
        pixel(10'd100, 10'd50);
        idle(2);
        total++; if (pixel_hit !== 1'b1) begin bad++; $display("[TB] FAIL pre_reset_hit: got %0d want 1", pixel_hit); end
        doCommit(5'd1);
        #2 Reset = 1'b1;
        #1;
        total++; if (pixel_hit !== 1'b0) begin bad++; $display("[TB] FAIL async_reset_hit: got %0d want 0", pixel_hit); end
        total++; if (pixel_color !== 5'd0) begin bad++; $display("[TB] FAIL async_reset_color: got %0d want 0", pixel_color); end
        total++; if (rom_idx !== 5'd0) begin bad++; $display("[TB] FAIL async_reset_idx: got %0d want 0", rom_idx); end
        total++; if (commit_pending !== 1'b0) begin bad++; $display("[TB] FAIL async_reset_pending: got %0d want 0", commit_pending); end
        tick();
        Reset = 1'b0;
        tick();
        pixel(10'd100, 10'd50);
        total++; if (rom_idx !== 5'h1f) begin bad++; $display("[TB] FAIL post_reset_blank: got %0d want 31", rom_idx); end
    endtask

    task automatic test_scale2x();
        writeSlot(4'd0, 5'd1);
        writeSlot(4'd1, 5'd2);
        doCommit(5'd2);
        doFrameStart(10'd0, 10'd0);
        pixel(10'd0, 10'd0);
        total++; if (rom_read_address !== 19'd0) begin bad++; $display("[TB] FAIL s2_x0: got %0d want 0", rom_read_address); end
        total++; if (rom_idx !== 5'd1) begin bad++; $display("[TB] FAIL s2_idx_x0: got %0d want 1", rom_idx); end
        pixel(10'd1, 10'd0);
        total++; if (rom_read_address !== 19'd0) begin bad++; $display("[TB] FAIL s2_x1: got %0d want 0", rom_read_address); end
        pixel(10'd2, 10'd0);
        total++; if (rom_read_address !== 19'd1) begin bad++; $display("[TB] FAIL s2_x2: got %0d want 1", rom_read_address); end
        for (int x = 3; x < 60; x++) pixel(10'(x), 10'd0);
        pixel(10'd60, 10'd0);
        total++; if (rom_idx !== 5'd2) begin bad++; $display("[TB] FAIL s2_glyph1_idx: got %0d want 2", rom_idx); end
        total++; if (rom_read_address !== 19'd0) begin bad++; $display("[TB] FAIL s2_glyph1_addr: got %0d want 0", rom_read_address); end
        pixel(10'd0, 10'd1);
        total++; if (rom_read_address !== 19'd0) begin bad++; $display("[TB] FAIL s2_y1: got %0d want 0", rom_read_address); end
        pixel(10'd0, 10'd2);
        total++; if (rom_read_address !== 19'd30) begin bad++; $display("[TB] FAIL s2_y2: got %0d want 30", rom_read_address); end
    endtask

    initial begin
        test_reset();
`ifdef GLYPH_SCALE2X_EN
        test_scale2x();
`else
        test_address_path();
        test_commit_midframe();
        test_back_to_back();
        test_saturation();
        test_len_zero();
        test_reset_midscan();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
